// File: rtl/mem_access_ctrl.sv
// Memory access controller: arbitrates a fetch port and a data port onto one
// memory through a LOAD -> WAIT -> DONE sequence, with round-robin on ties.
module mem_access_ctrl #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MEM_WAIT = 2
) (
  input  logic              MAC_clock,
  input  logic              MAC_reset_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ack,
  output logic [DATA_W-1:0] fetch_rdata,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_ack,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mar_load_en,
  output logic [ADDR_W-1:0] mar_addr,
  output logic              mem_en,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;

  typedef struct packed {
    logic              owner_data;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } txn_t;

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  state_t     state;
  txn_t       txn;
  txn_t       req_txn;
  logic [3:0] cnt;
  logic       last_data;
  logic       pick_data;

  // Data wins only when fetch is absent or fetch was served last.
  always_comb begin
    pick_data = data_req & (~fetch_req | ~last_data);
    req_txn   = '{owner_data: pick_data,
                  we:         pick_data & data_we,
                  addr:       pick_data ? data_addr : fetch_addr,
                  wdata:      pick_data ? data_wdata : '0};
  end

  // Outputs are registered alongside the state so each one reflects the
  // state being entered on the same edge.
  always_ff @(posedge MAC_clock or negedge MAC_reset_n) begin
    if (!MAC_reset_n) begin
      state       <= IDLE;
      txn         <= '0;
      cnt         <= '0;
      last_data   <= 1'b1;
      fetch_ack   <= 1'b0;
      data_ack    <= 1'b0;
      fetch_rdata <= '0;
      data_rdata  <= '0;
      mar_load_en <= 1'b0;
      mar_addr    <= '0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
      busy        <= 1'b0;
    end else begin
      mar_load_en <= 1'b0;
      mar_addr    <= '0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
      fetch_ack   <= 1'b0;
      data_ack    <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch_req || data_req) begin
            state       <= LOAD;
            txn         <= req_txn;
            last_data   <= pick_data;
            mar_load_en <= 1'b1;
            mar_addr    <= req_txn.addr;
            busy        <= 1'b1;
          end
        end
        LOAD: begin
          state     <= WAIT;
          cnt       <= 4'd1;
          mem_en    <= 1'b1;
          mem_we    <= txn.we;
          mem_wdata <= txn.wdata;
        end
        WAIT: begin
          if (cnt == WAIT_LAST) begin
            state     <= DONE;
            fetch_ack <= ~txn.owner_data;
            data_ack  <= txn.owner_data;
            if (!txn.we) begin
              if (txn.owner_data) data_rdata  <= mem_rdata;
              else                fetch_rdata <= mem_rdata;
            end
          end else begin
            cnt       <= cnt + 4'd1;
            mem_en    <= 1'b1;
            mem_we    <= txn.we;
            mem_wdata <= txn.wdata;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
